// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time, hands the returned word to
// decode with its address, and computes the next fetch address from the
// branch outcome on the decode handshake. A flush redirects fetch. If a
// response is still in flight, it is drained and discarded.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        br,
    input  logic        z,
    input  logic [19:0] extend,
    input  logic        flush,
    input  logic [19:0] flush_pc,
    output logic        imem_req,
    output logic [19:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [19:0] imem_rdata,
    output logic [19:0] ins,
    output logic [19:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] pc_q, pc_d;
    logic [19:0] ins_q, ins_d;
    logic [19:0] ins_pc_q, ins_pc_d;
    logic        ins_valid_q, ins_valid_d;

    // Address following the delivered instruction. The word offset is scaled
    // to bytes and everything wraps modulo 2^20.
    function automatic logic [19:0] next_pc(input logic [19:0] cur_pc,
                                            input logic        taken,
                                            input logic [19:0] offs);
        logic [19:0] byte_offs;
        byte_offs = taken ? {offs[17:0], 2'b00} : 20'd0;
        return cur_pc + 20'd4 + byte_offs;
    endfunction

    // Next-state, fetch address and decode-register update.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (flush) begin
                    pc_d = flush_pc;
                end else begin
                    pc_d = 20'h00000;
                end
            end
            S_REQ: begin
                if (flush) begin
                    // A grant in the flush cycle still launched a read that
                    // must be swallowed.
                    pc_d = flush_pc;
                    if (imem_gnt) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // Data arriving with the flush is dropped on the spot;
                    // otherwise the response is still owed and gets drained.
                    pc_d = flush_pc;
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (imem_rvalid) begin
                    ins_d       = imem_rdata;
                    ins_pc_d    = pc_q;
                    ins_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_d        = flush_pc;
                    ins_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else if (ins_ready) begin
                    pc_d        = next_pc(ins_pc_q, br && z, extend);
                    ins_valid_d = 1'b0;
                    state_d     = S_REQ;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    pc_d = flush_pc;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                pc_d        = 20'h00000;
                ins_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= 20'h00000;
            ins_q       <= 20'h00000;
            ins_pc_q    <= 20'h00000;
            ins_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
        end
    end

    // A flush (or reset) withdraws a pending request in the same cycle.
    assign imem_req  = (state_q == S_REQ) && !flush && !rst;
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_pc    = ins_pc_q;
    assign ins_valid = ins_valid_q;

endmodule
